// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl: request sequencer for an SR-latch SRAM cell array.
// Accepts one read or write at a time and drives sel / RW / Din in a glitch-safe order.
// For reads, it captures the OR-combined column outputs and returns them on a response channel.
// Optional feature: define SRAM_PARITY_EN to widen the array data by one even-parity bit
// and to add the rsp_perr output.
module sram_array_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_oor,
`ifdef SRAM_PARITY_EN
  output logic              rsp_perr,
`endif
  // cell array
  output logic [DEPTH-1:0]  arr_sel,
  output logic              arr_rw,
`ifdef SRAM_PARITY_EN
  output logic [DATA_W:0]   arr_din,
  input  logic [DATA_W:0]   arr_dout
`else
  output logic [DATA_W-1:0] arr_din,
  input  logic [DATA_W-1:0] arr_dout
`endif
);

`ifdef SRAM_PARITY_EN
  localparam int unsigned ArrW = DATA_W + 1;
`else
  localparam int unsigned ArrW = DATA_W;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWStrobe,
    StWRecover,
    StRSel,
    StRCapt,
    StRResp
  } state_e;

  // One-hot row decode; addresses at or beyond DEPTH decode to no row at all.
  function automatic logic [DEPTH-1:0] decode_row(input logic [ADDR_W-1:0] a);
    logic [DEPTH-1:0] rows;
    rows = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) rows[i] = 1'b1;
    end
    return rows;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                oor_q, oor_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_oor_q, rsp_oor_d;
  logic [DEPTH-1:0]    arr_sel_q, arr_sel_d;
  logic                arr_rw_q, arr_rw_d;
  logic [ArrW-1:0]     arr_din_q, arr_din_d;
`ifdef SRAM_PARITY_EN
  logic                rsp_perr_q, rsp_perr_d;
`endif

  logic                req_oor;
  logic [ArrW-1:0]     wdata_ext;

  assign req_oor = ({{(32 - ADDR_W){1'b0}}, req_addr} >= DEPTH);

`ifdef SRAM_PARITY_EN
  assign wdata_ext = {^req_wdata, req_wdata};
`else
  assign wdata_ext = req_wdata;
`endif

  // Next-state and next-output logic; every output is a flop so the array never sees glitches.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    oor_d       = oor_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_oor_d   = rsp_oor_q;
    arr_sel_d   = arr_sel_q;
    arr_rw_d    = arr_rw_q;
    arr_din_d   = arr_din_q;
`ifdef SRAM_PARITY_EN
    rsp_perr_d  = rsp_perr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          oor_d       = req_oor;
          req_ready_d = 1'b0;
          arr_rw_d    = 1'b1;
          if (req_we) begin
            // Data settles while the row is still deselected.
            state_d   = StWSetup;
            arr_din_d = wdata_ext;
            arr_sel_d = '0;
          end else begin
            state_d   = StRSel;
            arr_din_d = '0;
            arr_sel_d = decode_row(req_addr);
          end
        end
      end

      StWSetup: begin
        // Row select and write strobe go active together on stable data.
        state_d   = StWStrobe;
        arr_sel_d = decode_row(addr_q);
        arr_rw_d  = 1'b0;
      end

      StWStrobe: begin
        // Strobe and select drop together; data is still held.
        state_d   = StWRecover;
        arr_sel_d = '0;
        arr_rw_d  = 1'b1;
      end

      StWRecover: begin
        // Data may only change once the row is fully isolated.
        state_d     = StIdle;
        arr_din_d   = '0;
        req_ready_d = 1'b1;
      end

      StRSel: begin
        state_d = StRCapt;
      end

      StRCapt: begin
        state_d     = StRResp;
        arr_sel_d   = '0;
        rsp_valid_d = 1'b1;
        rsp_oor_d   = oor_q;
        rsp_rdata_d = oor_q ? '0 : arr_dout[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
        rsp_perr_d  = oor_q ? 1'b0 : ^arr_dout;
`endif
      end

      StRResp: begin
        // IDLE is always visited before the next accept.
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        arr_sel_d   = '0;
        arr_rw_d    = 1'b1;
        arr_din_d   = '0;
      end
    endcase
  end

  // State and registered outputs; async reset leaves the array in hold with nothing selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_oor_q   <= 1'b0;
      arr_sel_q   <= '0;
      arr_rw_q    <= 1'b1;
      arr_din_q   <= '0;
`ifdef SRAM_PARITY_EN
      rsp_perr_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      oor_q       <= oor_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_oor_q   <= rsp_oor_d;
      arr_sel_q   <= arr_sel_d;
      arr_rw_q    <= arr_rw_d;
      arr_din_q   <= arr_din_d;
`ifdef SRAM_PARITY_EN
      rsp_perr_q  <= rsp_perr_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_oor   = rsp_oor_q;
  assign arr_sel   = arr_sel_q;
  assign arr_rw    = arr_rw_q;
  assign arr_din   = arr_din_q;
`ifdef SRAM_PARITY_EN
  assign rsp_perr  = rsp_perr_q;
`endif

endmodule

// File: doc/sram_array_ctrl.md
Name: sram_array_ctrl

Overview:
Synchronous request sequencer that sits directly upstream of an array of SR-latch SRAM cells and drives their sel / RW / Din inputs. It accepts one read or write request at a time over a valid/ready handshake and decodes the address into a one-hot row select. It orders the select, read/write and data signals so a cell never sees a write strobe while its data or select lines are changing. For reads it captures the array's OR-combined column outputs and returns them on a valid/ready response channel.

Parameters:
ADDR_W, 4, request address width
DEPTH, 16, number of rows (words); must be <= 2**ADDR_W
DATA_W, 8, bits per word (cell columns)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes the response
rsp_rdata  output  DATA_W  captured read data
rsp_oor  output  1  response was for an out-of-range address
arr_sel  output  DEPTH  one-hot row select to the cells' sel inputs
arr_rw  output  1  cell RW: 1 = read/hold, 0 = write
arr_din  output  DATA_W(+1)  column write data to the cells' Din inputs
arr_dout  input  DATA_W(+1)  column outputs (o1 of the selected row)

Behaviour:
- All outputs are registered. No combinational path from input to output, except the async reset clear.
- Reset (async, any state): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_oor=0, arr_sel=0, arr_rw=1, arr_din=0.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. req_addr, req_we and req_wdata are latched at that edge.
- req_ready=1 only in IDLE. A response is held stable until rsp_valid && rsp_ready.
- FSM states: IDLE, W_SETUP, W_STROBE, W_RECOVER, R_SEL, R_CAPT, R_RESP.
- IDLE -> W_SETUP on accepted write; IDLE -> R_SEL on accepted read.
- W_SETUP (1 cycle): arr_din=wdata, arr_sel=0, arr_rw=1.
- W_STROBE (1 cycle): arr_sel=onehot(addr), arr_rw=0, arr_din held.
- W_RECOVER (1 cycle): arr_sel=0, arr_rw=1, arr_din held. Then -> IDLE.
- Write occupancy: acceptance edge + 3 cycles. req_ready returns to 1 on the 4th edge after acceptance. A write produces no response.
- R_SEL (1 cycle): arr_sel=onehot(addr), arr_rw=1, arr_din=0.
- R_CAPT (1 cycle): sel held. At the exiting edge, rsp_rdata<=arr_dout, then sel is cleared.
- R_RESP: rsp_valid=1, arr_sel=0. Exit to IDLE on rsp_ready. The transfer can complete in the first R_RESP cycle.
- Read latency: rsp_valid rises 3 edges after acceptance.
- arr_rw never changes in the same cycle that arr_sel goes to or from non-zero, except as specified for W_STROBE entry and exit. The W_SETUP and W_RECOVER cycles isolate those transitions.
- Out-of-range (addr >= DEPTH): the sequence still runs with arr_sel held 0. A write has no effect. A read returns rsp_rdata=0 with rsp_oor=1; otherwise rsp_oor=0.
- No simultaneous accept/complete: a new request is never accepted in the same cycle an R_RESP handshake completes; IDLE is visited for at least 1 cycle.
- Reset during W_STROBE aborts the write. The contents of that row are undefined afterwards; all other rows are unchanged.

Optional Feature:
SRAM_PARITY_EN
- Defined: arr_din/arr_dout are DATA_W+1 wide. Bit DATA_W carries even parity (^wdata) on writes. On reads, rsp_oor's sibling output rsp_perr (1 bit, reset 0) = ^arr_dout captured in R_CAPT. rsp_perr is forced 0 for out-of-range reads.
- Undefined: arr_din/arr_dout are DATA_W wide and the rsp_perr port does not exist.

Test Plan:
- Reset then idle: check req_ready=1, arr_sel=0, arr_rw=1, arr_din=0; assert rst mid-cycle and check the async clear.
- Write addr 5 data 0xA5: W_SETUP shows din=0xA5 with sel=0; W_STROBE shows sel=0x0020, rw=0; W_RECOVER shows sel=0; req_ready returns 4 edges after accept.
- Read addr 5 after that write (array model): rsp_valid 3 edges after accept, rsp_rdata=0xA5, rsp_oor=0. Hold rsp_ready=0 for 5 cycles and check data stays stable.
- Back-to-back write 0x3C to addr 15, then read addr 0 with req_valid held high: the second accept happens only after IDLE; read returns the addr-0 value with no corruption from addr 15.
- DEPTH=12, write then read addr 13: arr_sel stays 0 throughout; the read gives rsp_rdata=0x00, rsp_oor=1.
- SRAM_PARITY_EN: write 0x07 and check arr_din[8]=1. Force arr_dout bit 0 flipped on read and check rsp_perr=1; an unflipped read gives rsp_perr=0.
